// File: rtl/otter_fetch_stage_if.sv
// Fetch-stage bus bundle: hazard/redirect controls, instruction memory port,
// and the IF/ID register outputs toward decode.
interface otter_fetch_stage_if;
  logic        STALL;
  logic        REDIRECT;
  logic [31:0] REDIRECT_PC;
  logic [31:0] MEM_ADDR1;
  logic        MEM_READ1;
  logic [31:0] MEM_DOUT1;
  logic [31:0] DEC_IR;
  logic [31:0] DEC_PC;
  logic [31:0] DEC_PC4;
  logic        DEC_VALID;

  // Fetch stage side.
  modport master (
    input  STALL, REDIRECT, REDIRECT_PC, MEM_DOUT1,
    output MEM_ADDR1, MEM_READ1, DEC_IR, DEC_PC, DEC_PC4, DEC_VALID
  );

  // Environment side: memory, hazard unit, execute, decode.
  modport slave (
    output STALL, REDIRECT, REDIRECT_PC, MEM_DOUT1,
    input  MEM_ADDR1, MEM_READ1, DEC_IR, DEC_PC, DEC_PC4, DEC_VALID
  );
endinterface

// File: rtl/otter_fetch_stage.sv
// OTTER RV32I instruction-fetch stage. Issues one fetch per cycle into a
// synchronous memory, keeps a one-entry skid buffer so the word returning
// during a stall is not lost, and flushes on redirect.
module otter_fetch_stage #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR    = 32'h0000_0013
) (
  input  logic                CLK,
  input  logic                RST,
  otter_fetch_stage_if.master bus
);

  // p0: fetch PC about to be issued
  logic [31:0] r_pc_p0;
  // p1: request in flight (data on MEM_DOUT1 now) and the skid entry
  logic [31:0] r_f2_pc_p1;
  logic        r_f2_vld_p1;
  logic [31:0] r_hold_ir_p1;
  logic [31:0] r_hold_pc_p1;
  logic        r_hold_vld_p1;
  // p2: IF/ID register
  logic [31:0] r_dec_ir_p2;
  logic [31:0] r_dec_pc_p2;
  logic        r_dec_vld_p2;

  logic [31:0] w_redir_pc;
  logic        w_advance;
  logic        w_capture;

  // Redirect targets are word aligned; low two bits are dropped.
  assign w_redir_pc = bus.REDIRECT_PC & 32'hFFFF_FFFC;
  assign w_advance  = !bus.REDIRECT && !bus.STALL;
  assign w_capture  = !bus.REDIRECT && bus.STALL && r_f2_vld_p1;

  assign bus.MEM_ADDR1 = r_pc_p0;
  assign bus.MEM_READ1 = !RST && !bus.STALL && !bus.REDIRECT;
  assign bus.DEC_IR    = r_dec_ir_p2;
  assign bus.DEC_PC    = r_dec_pc_p2;
  assign bus.DEC_PC4   = r_dec_pc_p2 + 32'd4;
  assign bus.DEC_VALID = r_dec_vld_p2;

  // Control state and IF/ID register: redirect > stall > advance.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_pc_p0       <= RESET_VECTOR;
      r_f2_vld_p1   <= 1'b0;
      r_hold_vld_p1 <= 1'b0;
      r_dec_ir_p2   <= NOP_INSTR;
      r_dec_pc_p2   <= 32'h0000_0000;
      r_dec_vld_p2  <= 1'b0;
    end else if (bus.REDIRECT) begin
      r_pc_p0       <= w_redir_pc;
      r_f2_vld_p1   <= 1'b0;
      r_hold_vld_p1 <= 1'b0;
      r_dec_ir_p2   <= NOP_INSTR;
      r_dec_vld_p2  <= 1'b0;
    end else if (bus.STALL) begin
      // No request issued while stalled; park any returning word.
      r_f2_vld_p1 <= 1'b0;
      if (r_f2_vld_p1) begin
        r_hold_vld_p1 <= 1'b1;
      end
    end else begin
      // Oldest instruction first: skid entry, then the returning word.
      if (r_hold_vld_p1) begin
        r_dec_ir_p2  <= r_hold_ir_p1;
        r_dec_pc_p2  <= r_hold_pc_p1;
        r_dec_vld_p2 <= 1'b1;
      end else if (r_f2_vld_p1) begin
        r_dec_ir_p2  <= bus.MEM_DOUT1;
        r_dec_pc_p2  <= r_f2_pc_p1;
        r_dec_vld_p2 <= 1'b1;
      end else begin
        r_dec_ir_p2  <= NOP_INSTR;
        r_dec_vld_p2 <= 1'b0;
      end
      r_hold_vld_p1 <= 1'b0;
      r_f2_vld_p1   <= 1'b1;
      r_pc_p0       <= r_pc_p0 + 32'd4;
    end
  end

  // Datapath registers; qualified by their valid bits, so no reset needed.
  always_ff @(posedge CLK) begin
    if (w_advance) begin
      r_f2_pc_p1 <= r_pc_p0;
    end
    if (w_capture) begin
      r_hold_ir_p1 <= bus.MEM_DOUT1;
      r_hold_pc_p1 <= r_f2_pc_p1;
    end
  end

endmodule

// File: tb/tb_otter_fetch_stage.sv
// Directed bench for otter_fetch_stage. Memory returns 0x1000_0000|addr one
// cycle after the address is presented.
module tb_otter_fetch_stage;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic CLK;
  logic RST;
  int   total;
  int   bad;

  otter_fetch_stage_if bus ();

  otter_fetch_stage #(
    .RESET_VECTOR (32'h0000_0000),
    .NOP_INSTR    (NOP)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Synchronous instruction memory model.
  always @(posedge CLK) bus.MEM_DOUT1 <= 32'h1000_0000 | bus.MEM_ADDR1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one edge, sample 1ns later, and check the skid invariant.
  task automatic tick();
    @(posedge CLK);
    #1;
    if (!RST) chk("skid_excl", {31'd0, dut.r_hold_vld_p1 & dut.r_f2_vld_p1}, 32'd0);
  endtask

  task automatic chk_dec(input string tag, input logic vld, input logic [31:0] pc, input logic [31:0] ir);
    chk({tag, "_vld"}, {31'd0, bus.DEC_VALID}, {31'd0, vld});
    chk({tag, "_ir"}, bus.DEC_IR, ir);
    if (vld) begin
      chk({tag, "_pc"}, bus.DEC_PC, pc);
      chk({tag, "_pc4"}, bus.DEC_PC4, pc + 32'd4);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    RST   = 1'b1;
    bus.STALL       = 1'b0;
    bus.REDIRECT    = 1'b0;
    bus.REDIRECT_PC = 32'd0;
    tick();
    tick();
    // Reset state
    chk("rst_vld", {31'd0, bus.DEC_VALID}, 32'd0);
    chk("rst_ir", bus.DEC_IR, NOP);
    chk("rst_pc", bus.DEC_PC, 32'd0);
    chk("rst_addr", bus.MEM_ADDR1, 32'd0);
    chk("rst_read", {31'd0, bus.MEM_READ1}, 32'd0);
    RST = 1'b0;
    #1;
    chk("rel_read", {31'd0, bus.MEM_READ1}, 32'd1);

    // Streaming from reset vector
    tick();                                    // edge1: issue 0
    chk("e1_addr", bus.MEM_ADDR1, 32'h4);
    chk("e1_vld", {31'd0, bus.DEC_VALID}, 32'd0);
    tick();                                    // edge2
    chk_dec("e2", 1'b1, 32'h0, 32'h1000_0000);
    chk("e2_addr", bus.MEM_ADDR1, 32'h8);
    tick();
    chk_dec("e3", 1'b1, 32'h4, 32'h1000_0004);
    tick();
    chk_dec("e4", 1'b1, 32'h8, 32'h1000_0008);

    // Three-cycle stall while DEC_PC=8
    bus.STALL = 1'b1;
    #1;
    chk("st_read0", {31'd0, bus.MEM_READ1}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_dec("st_hold", 1'b1, 32'h8, 32'h1000_0008);
      chk("st_read", {31'd0, bus.MEM_READ1}, 32'd0);
    end
    bus.STALL = 1'b0;
    tick();
    chk_dec("st_rel1", 1'b1, 32'hC, 32'h1000_000C);
    tick();
    chk_dec("st_rel2", 1'b1, 32'h10, 32'h1000_0010);

    // Redirect to 0x200
    bus.REDIRECT    = 1'b1;
    bus.REDIRECT_PC = 32'h200;
    #1;
    chk("rd_read", {31'd0, bus.MEM_READ1}, 32'd0);
    tick();
    bus.REDIRECT = 1'b0;
    chk_dec("rd_b1", 1'b0, 32'h0, NOP);
    chk("rd_pc_kept", bus.DEC_PC, 32'h10);
    chk("rd_addr", bus.MEM_ADDR1, 32'h200);
    tick();
    chk_dec("rd_b2", 1'b0, 32'h0, NOP);
    tick();
    chk_dec("rd_t0", 1'b1, 32'h200, 32'h1000_0200);
    tick();
    chk_dec("rd_t1", 1'b1, 32'h204, 32'h1000_0204);

    // Stall to fill the skid buffer, then redirect to 0x203 with stall held
    bus.STALL = 1'b1;
    tick();
    chk("rs_hold_vld", {31'd0, dut.r_hold_vld_p1}, 32'd1);
    bus.REDIRECT    = 1'b1;
    bus.REDIRECT_PC = 32'h203;
    tick();
    bus.REDIRECT = 1'b0;
    bus.STALL    = 1'b0;
    chk_dec("rs_b1", 1'b0, 32'h0, NOP);
    chk("rs_pc_kept", bus.DEC_PC, 32'h204);
    chk("rs_addr", bus.MEM_ADDR1, 32'h200);
    tick();
    chk_dec("rs_b2", 1'b0, 32'h0, NOP);
    tick();
    chk_dec("rs_t0", 1'b1, 32'h200, 32'h1000_0200);
    tick();
    chk_dec("rs_t1", 1'b1, 32'h204, 32'h1000_0204);

    // Asynchronous reset between edges while the skid buffer is full
    bus.STALL = 1'b1;
    tick();
    chk("ar_hold_vld", {31'd0, dut.r_hold_vld_p1}, 32'd1);
    #2;
    RST = 1'b1;
    #1;
    chk("ar_vld", {31'd0, bus.DEC_VALID}, 32'd0);
    chk("ar_ir", bus.DEC_IR, NOP);
    chk("ar_addr", bus.MEM_ADDR1, 32'h0);
    chk("ar_hold", {31'd0, dut.r_hold_vld_p1}, 32'd0);
    bus.STALL = 1'b0;
    tick();
    RST = 1'b0;
    tick();
    chk("ar_e1_vld", {31'd0, bus.DEC_VALID}, 32'd0);
    tick();
    chk_dec("ar_e2", 1'b1, 32'h0, 32'h1000_0000);
    tick();
    chk_dec("ar_e3", 1'b1, 32'h4, 32'h1000_0004);

    // Redirect to top of address space, PC wraps to 0
    bus.REDIRECT    = 1'b1;
    bus.REDIRECT_PC = 32'hFFFF_FFFC;
    tick();
    bus.REDIRECT = 1'b0;
    chk_dec("wr_b1", 1'b0, 32'h0, NOP);
    tick();
    chk_dec("wr_b2", 1'b0, 32'h0, NOP);
    tick();
    chk_dec("wr_t0", 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC);
    chk("wr_pc4", bus.DEC_PC4, 32'h0);
    tick();
    chk_dec("wr_t1", 1'b1, 32'h0, 32'h1000_0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
